// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
// Shares one single-port data memory between the CPU datapath and the debug
// unit. At most one access is granted per clock. The CPU has fixed priority,
// but a debug request is forced through after STARVE_LIMIT consecutive CPU
// wins. Read data is returned one cycle after the accepting ack to whichever
// requester issued the read.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   cpu_req/write/addr/wdata       CPU request, held stable until cpu_ack
//   cpu_ack                        CPU request accepted this cycle (comb.)
//   cpu_rdata, cpu_rvalid          CPU read return
//   dbg_req/write/addr/wdata       debug request, held stable until dbg_ack
//   dbg_ack                        debug request accepted this cycle (comb.)
//   dbg_rdata, dbg_rvalid          debug read return
//   mem_write, mem_addr, mem_wdata memory drive
//   mem_rdata                      memory read data (address latched last edge)
module data_memory_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 11,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_rvalid,
  input  logic                  dbg_req,
  input  logic                  dbg_write,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_rvalid,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  // Grant decode states (combinational, re-evaluated every cycle)
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] GRANT_CPU = 2'd1;
  localparam logic [1:0] GRANT_DBG = 2'd2;

  logic [1:0]       grant_state;
  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] starve_cnt_next;
  logic             rd_pending_reg;
  logic             rd_pending_next;
  logic             rd_owner_reg;   // 0 = CPU, 1 = debug
  logic             rd_owner_next;
  logic             starve_hit;

  assign starve_hit = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));

  // Nothing is granted while reset is asserted, so no write can slip through.
  always_comb begin
    grant_state = IDLE;
    if (rst_n) begin
      if (cpu_req && !(dbg_req && starve_hit)) begin
        grant_state = GRANT_CPU;
      end else if (dbg_req) begin
        grant_state = GRANT_DBG;
      end
    end
  end

  assign cpu_ack = (grant_state == GRANT_CPU);
  assign dbg_ack = (grant_state == GRANT_DBG);

  // Idle cycles still present cpu_addr; the memory latches it harmlessly.
  always_comb begin
    mem_write = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    case (grant_state)
      GRANT_CPU: begin
        mem_write = cpu_write;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      GRANT_DBG: begin
        mem_write = dbg_write;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      default: begin
        mem_write = 1'b0;
      end
    endcase
  end

  // Count CPU wins only while debug is actually waiting; saturate at the limit.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!dbg_req || dbg_ack) begin
      starve_cnt_next = '0;
    end else if (cpu_ack && !starve_hit) begin
      starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end
  end

  assign rd_pending_next = (cpu_ack && !cpu_write) || (dbg_ack && !dbg_write);
  assign rd_owner_next   = dbg_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
      rd_pending_reg <= 1'b0;
      rd_owner_reg   <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      rd_pending_reg <= rd_pending_next;
      rd_owner_reg   <= rd_owner_next;
    end
  end

  // Read return is a pure pass-through of the memory output; the strobe is
  // also gated by rst_n so a read accepted just before reset never returns.
  assign cpu_rvalid = rst_n && rd_pending_reg && !rd_owner_reg;
  assign dbg_rvalid = rst_n && rd_pending_reg &&  rd_owner_reg;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single-port 2048x16 data memory between two requesters: the CPU datapath (load/store) and the debug unit (memory dump and preload).
- Grants at most one access per clock, drives the memory's write/address/data inputs, and routes read data back to the owning requester with a valid strobe.
- Uses fixed CPU priority, with a starvation guard that forces a debug grant after a bounded run of CPU wins.

Parameters:
- DATA_WIDTH, 16, memory word width.
- ADDR_WIDTH, 11, memory address width (2048 words).
- STARVE_LIMIT, 4, maximum consecutive CPU grants while a debug request is waiting; minimum 1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous reset, active low
- cpu_req  input  1  CPU access request
- cpu_write  input  1  1=write, 0=read
- cpu_addr  input  ADDR_WIDTH  CPU word address
- cpu_wdata  input  DATA_WIDTH  CPU write data
- cpu_ack  output  1  CPU request accepted this cycle
- cpu_rdata  output  DATA_WIDTH  CPU read data
- cpu_rvalid  output  1  cpu_rdata valid
- dbg_req  input  1  debug access request
- dbg_write  input  1  1=write, 0=read
- dbg_addr  input  ADDR_WIDTH  debug word address
- dbg_wdata  input  DATA_WIDTH  debug write data
- dbg_ack  output  1  debug request accepted this cycle
- dbg_rdata  output  DATA_WIDTH  debug read data
- dbg_rvalid  output  1  dbg_rdata valid
- mem_write  output  1  to memory write
- mem_addr  output  ADDR_WIDTH  to memory addr_data
- mem_wdata  output  DATA_WIDTH  to memory in_data
- mem_rdata  input  DATA_WIDTH  from memory out_data

Behaviour:
- Memory contract:
  - Write cycle: the word is stored at the edge.
  - Non-write cycle: the memory latches mem_addr at the edge, and mem_rdata reflects that address in the following cycle.
  - Every non-write cycle, including idle ones, overwrites the memory's latched address.
- Requester rules:
  - req, write, addr and wdata are held stable until ack.
  - ack is combinational and lasts one cycle per accepted transaction.
  - If req stays high after ack, the next transaction is a new request (back-to-back allowed, one per cycle).
- Grant selection each cycle (combinational):
  - Only one requester: it is granted.
  - Both requesting: CPU wins, unless starve_cnt == STARVE_LIMIT, in which case debug wins.
  - Neither requesting: no grant. mem_write=0 and mem_addr=cpu_addr.
- Memory drive: mem_write = granted requester's write bit AND grant. mem_addr and mem_wdata come from the granted requester.
- starve_cnt (registered, width clog2(STARVE_LIMIT+1)):
  - Increments on a CPU grant while dbg_req=1.
  - Clears to 0 on a debug grant or whenever dbg_req=0.
  - Saturates at STARVE_LIMIT.
- Read return pipeline: registered rd_pending (1 bit) and rd_owner (0=CPU, 1=debug).
  - Set on a granted read.
  - In the next cycle, the owner's rvalid=1 and its rdata=mem_rdata (pass-through).
  - The non-owner's rvalid=0.
  - rdata is don't-care when rvalid=0. The bench checks rdata only with rvalid.
- Read latency is exactly 1 cycle after ack, and is independent of what is granted in that next cycle.
  - Back-to-back reads give rvalid on consecutive cycles.
  - Read followed by write: rvalid still fires and returns the read address's data.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Reset (rst_n=0 at an edge):
  - starve_cnt=0, rd_pending=0.
  - While rst_n=0: cpu_ack=dbg_ack=0, mem_write=0, cpu_rvalid=dbg_rvalid=0.
- Reset mid-operation: a read accepted in the cycle before reset produces no rvalid. No write occurs while rst_n=0.
- Structure: FSM states IDLE, GRANT_CPU and GRANT_DBG for the grant decode, plus the rd_pending pipeline stage.

Test Plan:
1. Reset, then CPU write 0x1234 to addr 0x005, then CPU read 0x005 -> cpu_ack each cycle; cpu_rvalid=1 with cpu_rdata=0x1234 one cycle after the read ack; dbg_rvalid=0 throughout.
2. CPU and debug both request reads continuously with STARVE_LIMIT=4 -> grant order CPU,CPU,CPU,CPU,DBG repeating; starve_cnt returns to 0 after each DBG grant.
3. Debug write 0xBEEF to 0x7FF, then CPU reads 0x7FF in the next cycle -> cpu_rdata=0xBEEF one cycle later; boundary address has no wrap.
4. CPU read 0x010 (holds 0x00AA), then CPU write 0x010 ← 0x5555 in the next cycle -> cpu_rvalid=1 with 0x00AA; a following read returns 0x5555.
5. Debug read accepted, rst_n=0 on the next edge -> no dbg_rvalid; ack and mem_write stay 0 during reset; after release a fresh read works normally.
6. Only debug requests for 10 cycles -> 10 dbg_acks back-to-back; starve_cnt stays 0; cpu_ack=0.
